// File: rtl/mac_acc_4b.sv
// Multiply-accumulate tail: sums signed 4-bit product terms onto a bias with
// saturation, then holds the result behind a valid/ready handshake.
module mac_acc_4b #(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned RELU  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       prod,
  input  logic             in_last,
  input  logic [ACC_W-1:0] bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_sat
);

  typedef enum logic [0:0] {StAcc, StDone} state_e;

  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             first_q;
  logic             sat_q;
  logic             ready_q;
  logic             valid_q;

  logic             accept;
  logic [ACC_W:0]   base;
  logic [ACC_W:0]   sum;
  logic             ovf;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;

  // ready_q is registered so it stays low on the first edge after reset release
  assign accept = in_valid & ready_q;

  always_comb begin
    base  = first_q ? {bias[ACC_W-1], bias} : {acc_q[ACC_W-1], acc_q};
    sum   = base + {{(ACC_W-3){prod[3]}}, prod};
    // Overflow of the ACC_W-bit range shows up as disagreeing top two bits
    ovf   = sum[ACC_W] ^ sum[ACC_W-1];
    acc_d = ovf ? (sum[ACC_W] ? AccMin : AccMax) : sum[ACC_W-1:0];
    if (first_q) begin
      cnt_d = CNT_W'(1);
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      sat_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          ready_q <= 1'b1;
          if (accept) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= first_q ? ovf : (sat_q | ovf);
            first_q <= 1'b0;
            if (in_last) begin
              state_q <= StDone;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StAcc;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            first_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_cnt   = cnt_q;
  assign out_sat   = sat_q;
  assign out_data  = ((RELU != 0) && acc_q[ACC_W-1]) ? '0 : acc_q;

endmodule

// File: doc/mac_acc_4b.md
MAC_ACC_4B -- requirements
Module: mac_acc_4b

Interface
REQ-001 SHALL have parameter ACC_W, default 8, accumulator and result width in bits, two's complement.
REQ-002 SHALL have parameter CNT_W, default 8, term-counter width in bits.
REQ-003 SHALL have parameter RELU, default 0; when 1, the result is clamped at zero.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  prod, in_last and bias are valid this cycle.
REQ-007 SHALL have port in_ready  output  1  the block accepts a term this cycle.
REQ-008 SHALL have port prod  input  4  signed product term, taken from the 4-bit two's-complement multiplier output.
REQ-009 SHALL have port in_last  input  1  the current term is the final term of the vector.
REQ-010 SHALL have port bias  input  ACC_W  signed bias, sampled only on the first term of a vector.
REQ-011 SHALL have port out_valid  output  1  the result is available.
REQ-012 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-013 SHALL have port out_data  output  ACC_W  signed result.
REQ-014 SHALL have port out_cnt  output  CNT_W  number of terms accepted for this result.
REQ-015 SHALL have port out_sat  output  1  saturation occurred during this vector (sticky).

Function
REQ-016 SHALL have two states: ACC (accepting terms) and DONE (holding the result).
REQ-017 SHALL drive in_ready = 1 only in state ACC, and = 0 whenever rst_n is low.
REQ-018 SHALL accept a term only on a cycle where in_valid and in_ready are both 1; in_valid while in_ready is 0 is ignored.
REQ-019 SHALL, on the first accepted term of a vector, load acc = sat(sext(bias) + sext(prod)); on later terms, acc = sat(acc + sext(prod)).
REQ-020 SHALL compute each sum in ACC_W+1 bits and saturate to the range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-021 SHALL set out_sat when any saturation occurs in the vector; the flag clears at the start of the next vector.
REQ-022 SHALL increment the term counter on each accepted term, holding at all-ones instead of wrapping; the counter restarts at 1 on the first term of a vector.
REQ-023 SHALL, on an accepted term with in_last = 1, move ACC -> DONE; out_valid rises on the next cycle (latency 1 from the last term).
REQ-024 SHALL, in DONE, hold out_valid = 1 and keep out_data, out_cnt and out_sat stable until out_ready = 1.
REQ-025 SHALL, in DONE with out_ready = 1, move to ACC and drop out_valid on the next cycle, with the next term treated as the first term of a new vector.
REQ-026 SHALL take no new term in the same cycle a result is taken (no bypass); at best, a new vector's first term is accepted one cycle after out_ready.
REQ-027 SHALL drive out_data = (RELU and acc < 0) ? 0 : acc; out_sat is not affected by ReLU clamping.
REQ-028 SHALL treat a first term with in_last = 1 as a valid single-term vector.
REQ-029 SHALL hold out_valid = 0 while in state ACC.

Reset
REQ-030 SHALL, while rst_n is low (asynchronously), force state ACC, acc = 0, the counter to 0, the first-term flag to 1, out_valid = 0, out_data = 0, out_cnt = 0 and out_sat = 0.
REQ-031 SHALL, on reset mid-vector or in DONE, discard any partial or pending result; after release, the next term is a first term.
REQ-032 SHALL raise in_ready on the first clock after rst_n is released.

Verification
REQ-033 SHALL cover: ACC_W=8, RELU=0, bias=0, prod 3, -2, 5 (last) -> one cycle after the last term, out_valid=1, out_data=6, out_cnt=3, out_sat=0.
REQ-034 SHALL cover: RELU=1, bias=0, prod -8, -8 (last) -> out_data=0, out_cnt=2, out_sat=0; the same stimulus with RELU=0 -> out_data=-16.
REQ-035 SHALL cover saturation at both limits: bias=120, prod 7, 7 (last) -> out_data=127, out_sat=1; and bias=-125, prod -8 (last) -> out_data=-128, out_sat=1.
REQ-036 SHALL cover backpressure: out_ready held 0 for 5 cycles in DONE while in_valid=1 -> out_valid and out_data stable, in_ready=0, no term counted; when out_ready is pulsed to 1 -> out_valid=0 and in_ready=1 on the next cycle.
REQ-037 SHALL cover reset mid-vector: 2 terms accepted, then rst_n pulsed low -> all outputs 0 immediately; then bias=-3, prod -1 (last) -> out_data=-4, out_cnt=1.
REQ-038 SHALL cover counter saturation: CNT_W=2, 5 terms of prod=1, bias=0 -> out_cnt=3, out_data=5.
